// File: rtl/echip_clkgen_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : echip_clkgen_ctrl_if
// Description : Pattern configuration port of the clock generator controller.
//               It carries the valid/ready pattern write channel, the commit
//               request, and the commit status returned by the controller.
//   cfg_valid   master->slave  pattern write request
//   cfg_ready   slave->master  write accepted when cfg_valid & cfg_ready
//   cfg_sel     master->slave  0=phi1 1=phi2 2=phi1F 3=sclk
//   cfg_data    master->slave  pattern value, LSB emitted first
//   commit      master->slave  1-cycle shadow->active transfer request
//   commit_done slave->master  1-cycle pulse, active patterns updated
//   cfg_err     slave->master  sticky, last commit rejected (phi1/phi2 overlap)
// Revision    : 1.0  initial release
// ============================================================================
interface echip_clkgen_ctrl_if #(
  parameter int PAT_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_sel;
  logic [PAT_W-1:0] cfg_data;
  logic             commit;
  logic             commit_done;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_sel, cfg_data, commit,
    input  cfg_ready, commit_done, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_sel, cfg_data, commit,
    output cfg_ready, commit_done, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/echip_clkgen_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : echip_clkgen_ctrl
// Description : Controller for the modulator/filter clock generator
//               (phi1, phi2, phi1F, sclk). Holds shadow and active copies of
//               the four clock patterns, commits shadow->active atomically on
//               a frame boundary while running, rejects phi1/phi2 overlap, and
//               sequences start-up settling frames and clean shutdown.
//   clk        in   serializer clock
//   rst        in   synchronous reset, active-high
//   enable     in   1 = run, 0 = stop at the next frame end
//   cfg        if   pattern write / commit port (slave side)
//   pat_*      out  active patterns to the generator
//   phase      out  bit index of the pattern currently emitted
//   frame_end  out  last bit of the frame (not asserted in OFF)
//   gen_run    out  clock output gate to the generator
// Revision    : 1.0  initial release
// ============================================================================
module echip_clkgen_ctrl #(
  parameter int PAT_W          = 16,
  parameter int STARTUP_FRAMES = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     enable,
  echip_clkgen_ctrl_if.slave            cfg,
  output logic      [PAT_W-1:0]         pat_phi1,
  output logic      [PAT_W-1:0]         pat_phi2,
  output logic      [PAT_W-1:0]         pat_phi1f,
  output logic      [PAT_W-1:0]         pat_sclk,
  output logic      [$clog2(PAT_W)-1:0] phase,
  output logic                          frame_end,
  output logic                          gen_run
);

  localparam int PH_W   = $clog2(PAT_W);
  localparam int FCNT_W = $clog2(STARTUP_FRAMES + 1);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(PAT_W - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(STARTUP_FRAMES - 1);

  // Pattern slots, index = cfg_sel: 0 phi1, 1 phi2, 2 phi1F, 3 sclk
  localparam logic [3:0][PAT_W-1:0] DEF_PATS = {
    PAT_W'(16'hFF00),   // sclk
    PAT_W'(16'hFF00),   // phi1F
    PAT_W'(16'hFE00),   // phi2
    PAT_W'(16'h00FE)    // phi1
  };

  localparam logic [2:0] S_OFF   = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PEND  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [FCNT_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic [3:0][PAT_W-1:0]   shadow_q, shadow_d;
  logic [3:0][PAT_W-1:0]   active_q, active_d;
  logic                    commit_done_q, commit_done_d;
  logic                    cfg_err_q, cfg_err_d;

  logic                    cfg_ready;
  logic                    wr_acc;
  logic [3:0][PAT_W-1:0]   shadow_eff;
  logic                    ovl;
  logic                    commit_eval;
  logic                    commit_ok;
  logic                    copy_now;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_OFF;
      phase_q       <= '0;
      frame_cnt_q   <= '0;
      shadow_q      <= DEF_PATS;
      active_q      <= DEF_PATS;
      commit_done_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      frame_cnt_q   <= frame_cnt_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      commit_done_q <= commit_done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Write/commit evaluation. The overlap check sees a write accepted in the
  // same cycle as the commit, so the shadow bank is evaluated post-write.
  // --------------------------------------------------------------------------
  always_comb begin
    wr_acc     = cfg.cfg_valid && cfg_ready;
    shadow_eff = shadow_q;
    if (wr_acc) begin
      shadow_eff[cfg.cfg_sel] = cfg.cfg_data;
    end
    ovl         = |(shadow_eff[0] & shadow_eff[1]);
    // Commits are only evaluated where a transfer can be scheduled; in PEND
    // and STOP they are ignored and leave cfg_err untouched.
    commit_eval = cfg.commit &&
                  ((state_q == S_OFF) || (state_q == S_START) || (state_q == S_RUN));
    commit_ok   = commit_eval && !ovl;
    // With clocks gated off the copy is immediate; while running it waits for
    // the frame boundary so a frame never mixes old and new patterns.
    copy_now    = (commit_ok && ((state_q == S_OFF) || (state_q == S_START))) ||
                  ((state_q == S_PEND) && frame_end);
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF: begin
        if (enable) state_d = S_START;
      end
      S_START: begin
        if (!enable)                                state_d = S_OFF;
        else if (frame_end && frame_cnt_q == FCNT_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        // A commit wins over a falling enable; shutdown follows via PEND.
        if (commit_ok)    state_d = S_PEND;
        else if (!enable) state_d = S_STOP;
      end
      S_PEND: begin
        if (frame_end) state_d = enable ? S_RUN : S_STOP;
      end
      S_STOP: begin
        if (enable)         state_d = S_RUN;
        else if (frame_end) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase
  end

  always_comb begin
    // Phase restarts at 0 on entry to START and is parked at 0 in OFF.
    if ((state_q == S_OFF) || (state_d == S_OFF)) begin
      phase_d = '0;
    end else if (phase_q == PH_LAST) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + 1'b1;
    end

    if (state_q != S_START) begin
      frame_cnt_d = '0;
    end else if (frame_end) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    shadow_d      = shadow_eff;
    active_d      = copy_now ? shadow_eff : active_q;
    commit_done_d = copy_now;
    cfg_err_d     = commit_eval ? ovl : cfg_err_q;
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    gen_run   = (state_q == S_RUN) || (state_q == S_PEND) || (state_q == S_STOP);
    cfg_ready = (state_q != S_PEND);
    frame_end = (phase_q == PH_LAST) && (state_q != S_OFF);
  end

  assign cfg.cfg_ready   = cfg_ready;
  assign cfg.commit_done = commit_done_q;
  assign cfg.cfg_err     = cfg_err_q;
  assign pat_phi1        = active_q[0];
  assign pat_phi2        = active_q[1];
  assign pat_phi1f       = active_q[2];
  assign pat_sclk        = active_q[3];
  assign phase           = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_echip_clkgen_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_echip_clkgen_ctrl
// Description : Directed self-checking bench for echip_clkgen_ctrl: reset
//               state, start-up sequencing, framed commit, overlap rejection,
//               clean shutdown, immediate commit in OFF, reset during PEND.
// Revision    : 1.0  initial release
// ============================================================================
module tb_echip_clkgen_ctrl;

  localparam int PAT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [PAT_W-1:0] pat_phi1, pat_phi2, pat_phi1f, pat_sclk;
  logic [3:0]       phase;
  logic             frame_end;
  logic             gen_run;

  int n_checks = 0;
  int n_errors = 0;

  echip_clkgen_ctrl_if #(.PAT_W(PAT_W)) bus ();

  echip_clkgen_ctrl #(
    .PAT_W          (PAT_W),
    .STARTUP_FRAMES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .cfg       (bus.slave),
    .pat_phi1  (pat_phi1),
    .pat_phi2  (pat_phi2),
    .pat_phi1f (pat_phi1f),
    .pat_sclk  (pat_sclk),
    .phase     (phase),
    .frame_end (frame_end),
    .gen_run   (gen_run)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (!gen_run && n < 200) begin
      step();
      n++;
    end
    chk(tag, gen_run, 1'b1);
  endtask

  initial begin
    int n;
    int pulses;
    int last_ph;

    rst           = 1'b1;
    enable        = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_sel   = 2'd0;
    bus.cfg_data  = '0;
    bus.commit    = 1'b0;
    step();
    step();

    // ---------------- reset state ----------------
    chk("rst_phase",  phase,           4'd0);
    chk("rst_genrun", gen_run,         1'b0);
    chk("rst_ready",  bus.cfg_ready,   1'b1);
    chk("rst_done",   bus.commit_done, 1'b0);
    chk("rst_err",    bus.cfg_err,     1'b0);
    chk("rst_phi1",   pat_phi1,        16'h00FE);
    chk("rst_phi2",   pat_phi2,        16'hFE00);
    chk("rst_phi1f",  pat_phi1f,       16'hFF00);
    chk("rst_sclk",   pat_sclk,        16'hFF00);
    rst = 1'b0;
    step();
    chk("off_phase_hold", phase, 4'd0);

    // ---------------- 1: start-up ----------------
    enable = 1'b1;
    step();
    chk("start_genrun_low", gen_run, 1'b0);
    n = 0;
    while (!gen_run && n < 200) begin
      step();
      n++;
    end
    chk("startup_cycles", n,     64);
    chk("startup_phase",  phase, 4'd0);
    chk("startup_phi1",   pat_phi1, 16'h00FE);

    // ---------------- 2: framed commit ----------------
    bus.cfg_valid = 1'b1; bus.cfg_sel = 2'd0; bus.cfg_data = 16'h007F;
    step();
    bus.cfg_sel = 2'd1; bus.cfg_data = 16'h7F00;
    step();
    bus.cfg_valid = 1'b0;
    n = 0;
    while (phase != 4'd5 && n < 40) begin
      step();
      n++;
    end
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    chk("pend_ready_low", bus.cfg_ready, 1'b0);
    n = 1;
    while (!bus.cfg_ready && n < 40) begin
      if (phase == 4'd15) chk("pend_phi1_old", pat_phi1, 16'h00FE);
      step();
      if (!bus.cfg_ready) n++;
    end
    chk("pend_cycles",   n,               10);
    chk("commit_phase0", phase,           4'd0);
    chk("commit_done",   bus.commit_done, 1'b1);
    chk("commit_phi1",   pat_phi1,        16'h007F);
    chk("commit_phi2",   pat_phi2,        16'h7F00);
    step();
    chk("commit_done_1cyc", bus.commit_done, 1'b0);

    // ---------------- 3: overlap rejection ----------------
    bus.cfg_valid = 1'b1; bus.cfg_sel = 2'd1; bus.cfg_data = 16'h00FF;
    step();
    bus.cfg_valid = 1'b0;
    bus.commit    = 1'b1;
    step();
    bus.commit    = 1'b0;
    chk("ovl_err",   bus.cfg_err,   1'b1);
    chk("ovl_ready", bus.cfg_ready, 1'b1);
    pulses = 0;
    repeat (20) begin
      step();
      if (bus.commit_done) pulses++;
    end
    chk("ovl_no_done", pulses,      0);
    chk("ovl_phi2",    pat_phi2,    16'h7F00);
    chk("ovl_sticky",  bus.cfg_err, 1'b1);
    bus.cfg_valid = 1'b1; bus.cfg_sel = 2'd1; bus.cfg_data = 16'hFF00;
    bus.commit    = 1'b1;
    step();
    bus.cfg_valid = 1'b0;
    bus.commit    = 1'b0;
    chk("fix_err_clr", bus.cfg_err,   1'b0);
    chk("fix_pend",    bus.cfg_ready, 1'b0);
    n = 0;
    while (!bus.commit_done && n < 40) begin
      step();
      n++;
    end
    chk("fix_done",  bus.commit_done, 1'b1);
    chk("fix_phi2",  pat_phi2,        16'hFF00);
    chk("fix_phase", phase,           4'd0);

    // ---------------- 4: shutdown ----------------
    n = 0;
    while (phase != 4'd3 && n < 40) begin
      step();
      n++;
    end
    enable = 1'b0;
    step();
    n = 0;
    last_ph = -1;
    while (gen_run && n < 40) begin
      last_ph = phase;
      if (phase == 4'd15) chk("stop_frame_end", frame_end, 1'b1);
      n++;
      step();
    end
    chk("stop_run_cycles", n,       12);
    chk("stop_last_phase", last_ph, 15);
    chk("stop_phase0",     phase,   4'd0);
    step();
    step();
    step();
    chk("off_phase_still0", phase,     4'd0);
    chk("off_frame_end",    frame_end, 1'b0);

    // ---------------- 5: write + commit in OFF ----------------
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.cfg_valid = 1'b1; bus.cfg_sel = 2'd1; bus.cfg_data = 16'h0100;
    bus.commit    = 1'b1;
    step();
    bus.cfg_valid = 1'b0;
    bus.commit    = 1'b0;
    chk("off_err",  bus.cfg_err,     1'b0);
    chk("off_phi2", pat_phi2,        16'h0100);
    chk("off_phi1", pat_phi1,        16'h00FE);
    chk("off_done", bus.commit_done, 1'b1);
    step();
    chk("off_done_1cyc", bus.commit_done, 1'b0);

    // ---------------- 6: reset during PEND ----------------
    enable = 1'b1;
    wait_run("pend_rst_run");
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    chk("pend_rst_inpend", bus.cfg_ready, 1'b0);
    rst = 1'b1;
    step();
    chk("pend_rst_phase",  phase,           4'd0);
    chk("pend_rst_genrun", gen_run,         1'b0);
    chk("pend_rst_ready",  bus.cfg_ready,   1'b1);
    chk("pend_rst_phi2",   pat_phi2,        16'hFE00);
    chk("pend_rst_done",   bus.commit_done, 1'b0);
    rst    = 1'b0;
    enable = 1'b0;
    pulses = 0;
    repeat (20) begin
      step();
      if (bus.commit_done) pulses++;
    end
    chk("pend_rst_no_done", pulses, 0);
    // Shadow bank must also be back at defaults.
    bus.commit = 1'b1;
    step();
    bus.commit = 1'b0;
    chk("pend_rst_shadow_phi2", pat_phi2, 16'hFE00);
    chk("pend_rst_shadow_done", bus.commit_done, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
